// File: rtl/imem_fetch_responder_pkg.sv
// Shared fetch-path types: instruction word and address widths used by the PC, the
// instruction store and decode.
package imem_fetch_responder_pkg;

  localparam int IMEM_AW   = 5;
  localparam int IMEM_DW   = 16;
  localparam int RSP_DEPTH = 4;

  typedef logic [IMEM_AW-1:0] imem_addr_t;
  typedef logic [IMEM_DW-1:0] imem_word_t;

  typedef struct packed {
    imem_addr_t addr;
    imem_word_t data;
  } fetch_rsp_t;

endpackage

// File: rtl/imem_fetch_responder_fetch_rsp_fifo.sv
// In-order response FIFO of {addr, data} pairs with synchronous flush.
// The head entry is presented combinationally from the storage registers.
module fetch_rsp_fifo
  import imem_fetch_responder_pkg::*;
#(
  parameter int AW    = IMEM_AW,
  parameter int DW    = IMEM_DW,
  parameter int DEPTH = RSP_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [AW-1:0]                push_addr_i,
  input  logic [DW-1:0]                push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic                         valid_o,
  output logic [AW-1:0]                head_addr_o,
  output logic [DW-1:0]                head_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push_i && !flush_i;
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Flush wins over everything; a pop on the flush edge is simply absorbed.
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      addr_mem_q[wr_ptr_q] <= push_addr_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Entries are never reset, so the head is forced to zero whenever it is not valid.
  always_comb begin
    valid_o     = (count_q != '0);
    head_addr_o = valid_o ? addr_mem_q[rd_ptr_q] : '0;
    head_data_o = valid_o ? data_mem_q[rd_ptr_q] : '0;
    count_o     = count_q;
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-store fetch responder: registered store read feeding an in-order
// response FIFO so decode can stall without losing fetched words.
module imem_fetch_responder
  import imem_fetch_responder_pkg::*;
#(
  parameter int AW    = IMEM_AW,
  parameter int DW    = IMEM_DW,
  parameter int DEPTH = RSP_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] store_q [2**AW];

  logic          pend_q, pend_d;
  logic [AW-1:0] pend_addr_q;
  logic [DW-1:0] rd_data_q;

  logic          accept;
  logic          push;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;

  // Ready looks only at registered occupancy, so rsp_ready/flush never reach it.
  always_comb begin
    occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, pend_q};
    req_ready = (occupancy < (CW+1)'(DEPTH));
    accept    = req_valid && req_ready;
    pend_d    = accept;
    push      = pend_q && !flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Non-blocking write and read in one block give read-first behaviour on a collision.
  always_ff @(posedge clk) begin
    if (wr_en) store_q[wr_addr] <= wr_data;
    if (accept) begin
      pend_addr_q <= req_addr;
      rd_data_q   <= store_q[req_addr];
    end
  end

  fetch_rsp_fifo #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (push),
    .push_addr_i (pend_addr_q),
    .push_data_i (rd_data_q),
    .pop_i       (rsp_ready),
    .flush_i     (flush),
    .valid_o     (rsp_valid),
    .head_addr_o (rsp_addr),
    .head_data_o (rsp_data),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder: directed scenarios plus a random phase,
// checked against a queue-based reference of accepted fetches.
module tb_imem_fetch_responder;
  import imem_fetch_responder_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          flush;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_rsp_t    exp_q[$];
  logic [DW-1:0] ref_mem [32];
  bit            acc;

  imem_fetch_responder #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: every accepted fetch owes one response holding the store word seen
  // before any same-edge write; flush or reset cancels everything owed so far.
  always @(negedge clk) begin
    fetch_rsp_t e;
    #1;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (flush) exp_q.delete();
      if (req_valid && req_ready) begin
        e.addr = req_addr;
        e.data = ref_mem[req_addr];
        exp_q.push_back(e);
      end
    end
    if (wr_en) ref_mem[wr_addr] = wr_data;
  end

  // Monitor: compares each popped response and checks stall stability.
  bit         hold = 1'b0;
  fetch_rsp_t held;
  always @(negedge clk) begin
    fetch_rsp_t e;
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_addr", rsp_addr, held.addr);
        chk("hold_data", rsp_data, held.data);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_rsp: got addr %0d data %0h, required no response", rsp_addr, rsp_data);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_addr", rsp_addr, e.addr);
          chk("rsp_data", rsp_data, e.data);
        end
      end
      hold      = rsp_valid && !rsp_ready && !flush;
      held.addr = rsp_addr;
      held.data = rsp_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    flush     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rsp_ready = 1'b0;
    repeat (2) step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    reset = 1'b0;
    step();

    // Program load, then reset (store must survive it).
    for (int i = 0; i < 32; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = 16'h1000 + DW'(i);
      step();
    end
    wr_en = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Streaming fetch: latency of two edges, then one response per cycle.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 5'd0;
    step();
    chk("lat_after_accept", rsp_valid, 0);
    req_addr = 5'd1;
    step();
    chk("lat_two_edges", rsp_valid, 1);
    chk("first_rsp_addr", rsp_addr, 0);
    chk("first_rsp_data", rsp_data, 16'h1000);
    for (int i = 2; i < 16; i++) begin
      chk("thru_ready", req_ready, 1);
      chk("thru_valid", rsp_valid, 1);
      req_addr = AW'(i);
      step();
    end
    req_valid = 1'b0;
    repeat (4) step();

    // Backpressure: four accepts fill the FIFO, head stays stable.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int a = 5; a < 9; a++) begin
      req_addr = AW'(a);
      chk("bp_ready_before_full", req_ready, 1);
      step();
    end
    req_addr = 5'd9;
    chk("bp_ready_drops", req_ready, 0);
    repeat (3) begin
      step();
      chk("bp_ready_full", req_ready, 0);
      chk("bp_head_addr", rsp_addr, 5);
      chk("bp_head_data", rsp_data, 16'h1005);
    end
    rsp_ready = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 10; c++) begin
      acc = req_ready;
      step();
      if (acc) break;
    end
    chk("bp_accept_9", acc, 1);
    req_valid = 1'b0;
    repeat (6) step();

    // Flush with a redirect request on the same edge.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int a = 10; a < 13; a++) begin
      req_addr = AW'(a);
      step();
    end
    req_valid = 1'b0;
    repeat (2) step();
    chk("fl_ready_with_3", req_ready, 1);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 5'd20;
    step();
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("fl_valid_drop", rsp_valid, 0);
    step();
    chk("fl_new_valid", rsp_valid, 1);
    chk("fl_new_addr", rsp_addr, 20);
    chk("fl_new_data", rsp_data, 16'h1014);
    rsp_ready = 1'b1;
    repeat (4) step();
    chk("fl_empty_after", rsp_valid, 0);

    // Read-first collision between a store write and a fetch of the same address.
    req_valid = 1'b1;
    req_addr  = 5'd3;
    wr_en     = 1'b1;
    wr_addr   = 5'd3;
    wr_data   = 16'hBEEF;
    step();
    wr_en = 1'b0;
    step();
    req_valid = 1'b0;
    chk("rf_old_word", rsp_data, 16'h1003);
    step();
    chk("rf_new_word", rsp_data, 16'hBEEF);
    repeat (4) step();

    // Address wrap 31 -> 0.
    req_valid = 1'b1;
    req_addr  = 5'd31;
    step();
    req_addr = 5'd0;
    step();
    req_valid = 1'b0;
    chk("wrap_31_data", rsp_data, 16'h101F);
    step();
    chk("wrap_0_data", rsp_data, 16'h1000);
    repeat (4) step();

    // Asynchronous reset with two buffered entries and one pending.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int a = 7; a < 10; a++) begin
      req_addr = AW'(a);
      step();
    end
    req_valid = 1'b0;
    chk("ar_valid_before", rsp_valid, 1);
    reset = 1'b1;
    #1;
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_req_ready", req_ready, 1);
    chk("ar_rsp_data", rsp_data, 0);
    step();
    step();
    reset     = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("ar_no_stale", rsp_valid, 0);
    end
    req_valid = 1'b1;
    req_addr  = 5'd4;
    step();
    req_valid = 1'b0;
    step();
    chk("ar_new_addr", rsp_addr, 4);
    repeat (3) step();

    // Random traffic: requests, stalls, flushes and program writes interleaved.
    for (int c = 0; c < 400; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = AW'($urandom_range(0, 31));
      rsp_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      wr_en     = ($urandom_range(0, 9) == 0);
      wr_addr   = AW'($urandom_range(0, 31));
      wr_data   = DW'($urandom);
      step();
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    wr_en     = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    step();
    chk("drain_empty", exp_q.size(), 0);
    chk("final_rsp_valid", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
